// File: rtl/uart_pm_pkg.sv
// uart_pm_pkg: shared constants and state encoding for the uart pattern matcher
package uart_pm_pkg;
  localparam int PM_MAX_LEN = 8;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_ARMED   = 2'd2,
    ST_MATCHED = 2'd3
  } pm_state_t;
endpackage

// File: rtl/pm_window_cmp.sv
// pm_window_cmp: byte history shift register with length-masked pattern comparator
module pm_window_cmp
  import uart_pm_pkg::*;
#(
  parameter int MAX_LEN = PM_MAX_LEN,
  parameter int LEN_W = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             shift_en,
  input  logic                             clr,
  input  logic [BYTE_W-1:0]                byte_in,
  input  logic [MAX_LEN-1:0][BYTE_W-1:0]   pattern,
  input  logic [LEN_W-1:0]                 len,
  output logic                             hit
);
  logic [MAX_LEN-2:0][BYTE_W-1:0] hist;
  logic [MAX_LEN-1:0][BYTE_W-1:0] win;
  assign win = {hist, byte_in};
  always_ff @(posedge clk)
    if (rst || clr) hist <= '0;
    else if (shift_en) hist <= win[MAX_LEN-2:0];
  always_comb begin
    hit = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      for (int k = 0; k < MAX_LEN; k++)
        if (i + k == int'(len) - 1) hit = hit && (win[i] == pattern[k]);
  end
endmodule

// File: rtl/uart_pattern_ctrl.sv
// uart_pattern_ctrl: loads a byte pattern, then counts sliding-window hits on the rx stream
module uart_pattern_ctrl
  import uart_pm_pkg::*;
#(
  parameter int MAX_LEN = PM_MAX_LEN,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_wr,
  input  logic [BYTE_W-1:0] cfg_byte,
  input  logic              arm,
  input  logic              stop_on_match,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic [1:0]        state,
  output logic              cfg_err
);
  localparam logic [LEN_W:0] MAX_V = (LEN_W+1)'(MAX_LEN);
  pm_state_t st, st_nxt;
  logic [MAX_LEN-1:0][BYTE_W-1:0] pattern;
  logic [LEN_W-1:0] len, wptr, fill;
  logic pat_valid, len_ok, live, arm_go, arm_err, wr_go, load_done, shift_en, fill_ok, win_hit, hit_now;
  assign state = st;
  always_ff @(posedge sys_clk)
    if (reset) st <= ST_IDLE;
    else st <= st_nxt;
  always_comb begin
    live = st == ST_ARMED || st == ST_MATCHED;
    len_ok = cfg_len != '0 && {1'b0, cfg_len} <= MAX_V;
    arm_go = !cfg_start && arm && (live || (st == ST_IDLE && pat_valid));
    arm_err = !cfg_start && arm && (st == ST_LOAD || (st == ST_IDLE && !pat_valid));
    wr_go = !cfg_start && cfg_wr && st == ST_LOAD;
    load_done = wr_go && ({1'b0, wptr} + 1'b1 == {1'b0, len});
    shift_en = !cfg_start && !arm && rx_valid && st == ST_ARMED;
    fill_ok = {1'b0, fill} + 1'b1 >= {1'b0, len};
    hit_now = shift_en && win_hit && fill_ok;
    st_nxt = cfg_start ? (len_ok ? ST_LOAD : ST_IDLE) :
             arm_go ? ST_ARMED :
             load_done ? ST_IDLE :
             (hit_now && stop_on_match) ? ST_MATCHED : st;
  end
  always_ff @(posedge sys_clk)
    if (reset) pattern <= '0;
    else
      for (int i = 0; i < MAX_LEN; i++)
        if (wr_go && wptr == LEN_W'(i)) pattern[i] <= cfg_byte;
  always_ff @(posedge sys_clk)
    if (reset) begin
      len <= '0;
      wptr <= '0;
      fill <= '0;
      pat_valid <= 1'b0;
      cfg_err <= 1'b0;
      match_count <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= hit_now;
      if (cfg_start) begin
        cfg_err <= !len_ok;
        if (len_ok) begin
          len <= cfg_len;
          wptr <= '0;
          fill <= '0;
          pat_valid <= 1'b0;
        end
      end else if (arm_err) cfg_err <= 1'b1;
      if (wr_go) wptr <= wptr + 1'b1;
      if (load_done) pat_valid <= 1'b1;
      if (arm_go) begin
        fill <= '0;
        match_count <= '0;
      end else begin
        if (shift_en && {1'b0, fill} != MAX_V) fill <= fill + 1'b1;
        if (hit_now && !(&match_count)) match_count <= match_count + 1'b1;
      end
    end
  pm_window_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_win (
    .clk(sys_clk),
    .rst(reset),
    .shift_en(shift_en),
    .clr(cfg_start || arm_go),
    .byte_in(rx_data),
    .pattern(pattern),
    .len(len),
    .hit(win_hit)
  );
endmodule

// File: tb/tb_uart_pattern_ctrl.sv
// tb_uart_pattern_ctrl: directed and randomized checks against a queue-based reference model
module tb_uart_pattern_ctrl;
  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_start = 1'b0, cfg_wr = 1'b0, arm = 1'b0, stop_on_match = 1'b0, rx_valid = 1'b0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_byte = '0, rx_data = '0;
  logic mp16, mp2, err16, err2;
  logic [15:0] cnt16;
  logic [1:0] cnt2, st16, st2;
  int vectors = 0;
  int errors = 0;
  int m_state, m_len, m_wcnt, m_hits;
  bit m_valid, m_err, m_pulse;
  logic [7:0] m_pat[8];
  logic [7:0] m_hist[$];

  always #20 sys_clk = ~sys_clk;

  uart_pattern_ctrl u16 (
    .sys_clk(sys_clk), .reset(reset), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_wr(cfg_wr),
    .cfg_byte(cfg_byte), .arm(arm), .stop_on_match(stop_on_match), .rx_data(rx_data),
    .rx_valid(rx_valid), .match_pulse(mp16), .match_count(cnt16), .state(st16), .cfg_err(err16)
  );
  uart_pattern_ctrl #(.CNT_W(2)) u2 (
    .sys_clk(sys_clk), .reset(reset), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_wr(cfg_wr),
    .cfg_byte(cfg_byte), .arm(arm), .stop_on_match(stop_on_match), .rx_data(rx_data),
    .rx_valid(rx_valid), .match_pulse(mp2), .match_count(cnt2), .state(st2), .cfg_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit cs, input int cl, input bit wr, input logic [7:0] b,
                            input bit am, input bit rv, input logic [7:0] d);
    int s;
    bit hit;
    s = m_state;
    m_pulse = 1'b0;
    if (reset) begin
      m_state = 0; m_len = 0; m_wcnt = 0; m_hits = 0; m_valid = 0; m_err = 0;
      m_hist.delete();
      return;
    end
    if (cs) begin
      if (cl >= 1 && cl <= 8) begin
        m_state = 1; m_len = cl; m_wcnt = 0; m_err = 0; m_valid = 0;
      end else begin
        m_state = 0; m_err = 1;
      end
      return;
    end
    if (am) begin
      if (s >= 2 || (s == 0 && m_valid)) begin
        m_state = 2; m_hits = 0;
        m_hist.delete();
      end else m_err = 1;
    end
    if (s == 1 && wr) begin
      m_pat[m_wcnt] = b;
      m_wcnt++;
      if (m_wcnt == m_len) begin
        m_state = 0; m_valid = 1;
      end
    end
    if (s == 2 && rv && !am) begin
      m_hist.push_back(d);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      hit = m_hist.size() >= m_len;
      if (hit)
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - m_len + k] != m_pat[k]) hit = 0;
      if (hit) begin
        m_pulse = 1; m_hits++;
        if (stop_on_match) m_state = 3;
      end
    end
  endtask

  task automatic cyc(input bit cs, input int cl, input bit wr, input logic [7:0] b,
                     input bit am, input bit rv, input logic [7:0] d);
    cfg_start = cs; cfg_len = cl[3:0]; cfg_wr = wr; cfg_byte = b; arm = am; rx_valid = rv; rx_data = d;
    @(posedge sys_clk);
    model_step(cs, cl, wr, b, am, rv, d);
    #1;
    chk("state", 32'(st16), 32'(m_state));
    chk("state_c2", 32'(st2), 32'(m_state));
    chk("match_pulse", 32'(mp16), 32'(m_pulse));
    chk("match_pulse_c2", 32'(mp2), 32'(m_pulse));
    chk("match_count", 32'(cnt16), 32'(m_hits > 65535 ? 65535 : m_hits));
    chk("match_count_c2", 32'(cnt2), 32'(m_hits > 3 ? 3 : m_hits));
    chk("cfg_err", 32'(err16), 32'(m_err));
    chk("cfg_err_c2", 32'(err2), 32'(m_err));
    cfg_start = 0; cfg_wr = 0; arm = 0; rx_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
  endtask
  task automatic send(input logic [7:0] d);
    cyc(0, 0, 0, 8'h00, 0, 1, d);
  endtask
  task automatic do_arm();
    cyc(0, 0, 0, 8'h00, 1, 0, 8'h00);
  endtask
  task automatic load(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    cyc(1, n, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, i == 0 ? b0 : i == 1 ? b1 : b2, 0, 0, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("reset_state", 32'(st16), 32'd0);
    chk("reset_count", 32'(cnt16), 32'd0);
    load(2, 8'h41, 8'h42, 8'h00);
    do_arm();
    send(8'h41);
    send(8'h42);
    chk("t1_pulse", 32'(mp16), 32'd1);
    chk("t1_count", 32'(cnt16), 32'd1);
    idle(1);
    chk("t1_state", 32'(st16), 32'd2);
    do_arm();
    send(8'h41); send(8'h41); send(8'h42); send(8'h42);
    idle(1);
    chk("t2_count", 32'(cnt16), 32'd1);
    load(2, 8'h41, 8'h41, 8'h00);
    do_arm();
    repeat (4) send(8'h41);
    idle(1);
    chk("t3_count", 32'(cnt16), 32'd3);
    repeat (3) send(8'h41);
    idle(1);
    chk("sat_count_c2", 32'(cnt2), 32'd3);
    chk("sat_count", 32'(cnt16), 32'd6);
    stop_on_match = 1'b1;
    load(2, 8'hD6, 8'h35, 8'h00);
    do_arm();
    send(8'hD6); send(8'h35);
    chk("t4_pulse", 32'(mp16), 32'd1);
    chk("t4_state", 32'(st16), 32'd3);
    send(8'hD6); send(8'h35);
    idle(1);
    chk("t4_hold", 32'(cnt16), 32'd1);
    do_arm();
    chk("t4_rearm_state", 32'(st16), 32'd2);
    chk("t4_rearm_count", 32'(cnt16), 32'd0);
    stop_on_match = 1'b0;
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("len0_err", 32'(err16), 32'd1);
    chk("len0_state", 32'(st16), 32'd0);
    cyc(1, 9, 0, 8'h00, 0, 0, 8'h00);
    cyc(1, 3, 0, 8'h00, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h11, 0, 0, 8'h00);
    do_arm();
    chk("short_arm_err", 32'(err16), 32'd1);
    chk("short_arm_state", 32'(st16), 32'd1);
    load(2, 8'h41, 8'h42, 8'h00);
    do_arm();
    send(8'h41);
    cyc(0, 0, 0, 8'h00, 1, 1, 8'h42);
    send(8'h42);
    send(8'h41);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(8'h42);
    chk("rst_nopulse", 32'(mp16), 32'd0);
    do_arm();
    chk("rst_arm_err", 32'(err16), 32'd1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) stop_on_match = ~stop_on_match;
      reset = $urandom_range(0, 599) == 0;
      cyc($urandom_range(0, 39) == 0, int'($urandom_range(0, 10)), $urandom_range(0, 2) == 0,
          8'h41 + 8'($urandom_range(0, 1)), $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
          8'h41 + 8'($urandom_range(0, 3) == 0 ? 2 : $urandom_range(0, 1)));
    end
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
